// File: rtl/fle_pkg.sv
// fle_pkg: shared types, config-word sizing and mode-bit offsets for the fracturable logic element
package fle_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, COMMIT, ERR} fle_state_e;
    // Mode bits sit directly above the 2^K-bit truth table; offsets are relative to bit 2^K
    localparam int TT_LSB = 0;
    localparam int FRAC_BIT = 0;
    localparam int FF0_BIT = 1;
    localparam int FF1_BIT = 2;
    function automatic int cfg_w(input int k);
        return (1 << k) + 3;
    endfunction
endpackage

// File: rtl/fle_lut_core.sv
// fle_lut_core: K-input truth-table mux, optionally split into two (K-1)-input LUTs
module fle_lut_core #(
    parameter int K = 6
) (
    input  logic [(1<<K)-1:0] tt,
    input  logic              frac,
    input  logic [K-1:0]      idx,
    output logic [1:0]        o
);
    always_comb begin
        o[0] = frac ? tt[{1'b0, idx[K-2:0]}] : tt[idx];
        o[1] = frac & tt[{1'b1, idx[K-2:0]}];
    end
endmodule

// File: rtl/fle_frac_cfg_loader.sv
// fle_frac_cfg_loader: fracturable LUT element with serial shadow/active config loader
// Optional FLE_CFG_READBACK_EN registers the shadow MSB onto cfg_sout for daisy-chaining/readback.
module fle_frac_cfg_loader
    import fle_pkg::*;
#(
    parameter int K = 6,
    parameter int CFG_W = cfg_w(K),
    parameter int CNT_W = $clog2(CFG_W + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [K-1:0] fle_in,
    input  logic         fle_ce,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic         cfg_data,
    input  logic         cfg_last,
    input  logic         cfg_abort,
    output logic         cfg_done,
    output logic         cfg_err,
    output logic [1:0]   fle_out,
    output logic         cfg_sout
);
    localparam int TTW = 1 << K;
    fle_state_e state;
    logic [CFG_W-1:0] shadow, active;
    logic [CNT_W-1:0] cnt;
    logic [1:0] o, q;
    logic beat, at_end;
    assign beat = cfg_valid & cfg_ready;
    assign at_end = cnt == CNT_W'(CFG_W - 1);
    fle_lut_core #(.K(K)) u_core (
        .tt(active[TT_LSB +: TTW]),
        .frac(active[TTW + FRAC_BIT]),
        .idx(fle_in),
        .o(o)
    );
    // IDLE and LOAD share beat handling: cnt is always 0 in IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            shadow <= '0;
            active <= '0;
            cnt <= '0;
            cfg_ready <= 1'b1;
            cfg_done <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            if (cfg_abort) begin
                state <= IDLE;
                cnt <= '0;
                cfg_err <= 1'b0;
                cfg_ready <= 1'b1;
            end else begin
                if (beat) shadow <= {shadow[CFG_W-2:0], cfg_data};
                case (state)
                    IDLE, LOAD: if (beat) begin
                        if (cfg_last && at_end) begin
                            state <= COMMIT;
                            cfg_done <= 1'b1;
                            cfg_ready <= 1'b0;
                        end else if (cfg_last || at_end) begin
                            state <= ERR;
                            cfg_err <= 1'b1;
                            cfg_ready <= 1'b0;
                        end else begin
                            state <= LOAD;
                            cnt <= cnt + 1'b1;
                        end
                    end
                    COMMIT: begin
                        active <= shadow;
                        state <= IDLE;
                        cnt <= '0;
                        cfg_ready <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) q <= '0;
        else if (fle_ce) q <= o;
    end
    assign fle_out[0] = active[TTW + FF0_BIT] ? q[0] : o[0];
    assign fle_out[1] = active[TTW + FF1_BIT] ? q[1] : o[1];
`ifdef FLE_CFG_READBACK_EN
    always_ff @(posedge clk) begin
        if (reset) cfg_sout <= 1'b0;
        else if (beat && !cfg_abort) cfg_sout <= shadow[CFG_W-1];
    end
`else
    assign cfg_sout = 1'b0;
`endif
endmodule
